// File: rtl/lea_round_ctrl.sv
// lea_round_ctrl: LEA round sequencer. After a start request it steps a bounded,
// stallable round index and, for each round, presents the rotated key-schedule
// constant ROL32(delta[i mod n], i).
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-low reset
//   start         run request, sampled only in IDLE
//   key_len[1:0]  00=128, 01=192, 10=256, 11=illegal; latched with start
//   stall         downstream not ready; freezes the sequencer
//   busy          high in RUN and DONE
//   round_en      round round_idx is valid this cycle
//   round_idx     current round index
//   delta_rot     ROL32(delta[round_idx mod n], round_idx)
//   last_round    round_en on the final round
//   done          one-cycle pulse after the last round
//   err           one-cycle pulse on a start with illegal key_len
module lea_round_ctrl #(
    parameter int unsigned ROUNDS_128 = 24,
    parameter int unsigned ROUNDS_192 = 28,
    parameter int unsigned ROUNDS_256 = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  key_len,
    input  logic        stall,
    output logic        busy,
    output logic        round_en,
    output logic [4:0]  round_idx,
    output logic [31:0] delta_rot,
    output logic        last_round,
    output logic        done,
    output logic        err
);

    localparam int unsigned IDX_W = 5;
    localparam logic [IDX_W-1:0] LAST_128 = IDX_W'(ROUNDS_128 - 1);
    localparam logic [IDX_W-1:0] LAST_192 = IDX_W'(ROUNDS_192 - 1);
    localparam logic [IDX_W-1:0] LAST_256 = IDX_W'(ROUNDS_256 - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       klen_q, klen_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] last_idx;
    logic [2:0]       dsel;
    logic [31:0]      delta_base;
    logic [63:0]      delta_dbl;

    // Last round index for the latched key length
    always_comb begin
        last_idx = LAST_128;
        case (klen_q)
            2'b01:   last_idx = LAST_192;
            2'b10:   last_idx = LAST_256;
            default: last_idx = LAST_128;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            klen_q  <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            klen_q  <= klen_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        klen_d  = klen_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (key_len == 2'b11) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        klen_d  = key_len;
                        idx_d   = '0;
                    end
                end
            end
            RUN: begin
                if (!stall) begin
                    if (idx_q == last_idx) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Delta table index: i mod n with n = 4/6/8
    always_comb begin
        dsel = 3'(idx_q[1:0]);
        case (klen_q)
            2'b01:   dsel = 3'(idx_q % IDX_W'(6));
            2'b10:   dsel = idx_q[2:0];
            default: dsel = 3'(idx_q[1:0]);
        endcase
    end

    always_comb begin
        delta_base = 32'hc3efe9db;
        case (dsel)
            3'd0: delta_base = 32'hc3efe9db;
            3'd1: delta_base = 32'h44626b02;
            3'd2: delta_base = 32'h79e27c8a;
            3'd3: delta_base = 32'h78df30ec;
            3'd4: delta_base = 32'h715ea49e;
            3'd5: delta_base = 32'hc785da0a;
            3'd6: delta_base = 32'he04ef22a;
            3'd7: delta_base = 32'he5c40957;
            default: delta_base = 32'hc3efe9db;
        endcase
    end

    // Rotate-left by round index: upper half of the doubled word shifted left
    assign delta_dbl = {delta_base, delta_base} << idx_q;
    assign delta_rot = delta_dbl[63:32];

    assign round_idx  = idx_q;
    assign busy       = (state_q == RUN) || (state_q == DONE);
    assign round_en   = (state_q == RUN) && !stall;
    assign last_round = round_en && (idx_q == last_idx);
    assign done       = (state_q == DONE);
    assign err        = err_q;

endmodule

// File: tb/tb_lea_round_ctrl.sv
// tb_lea_round_ctrl: directed bench for lea_round_ctrl with hand-computed expectations.
module tb_lea_round_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  key_len;
    logic        stall;
    logic        busy;
    logic        round_en;
    logic [4:0]  round_idx;
    logic [31:0] delta_rot;
    logic        last_round;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    lea_round_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_len    (key_len),
        .stall      (stall),
        .busy       (busy),
        .round_en   (round_en),
        .round_idx  (round_idx),
        .delta_rot  (delta_rot),
        .last_round (last_round),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // One run: start with kl, optional per-cycle stall mask (bit c = run cycle c),
    // expected cycle index of the done pulse, start held high, mid-run start poke.
    task automatic run_check(input logic [1:0] kl, input int n, input logic [63:0] smask,
                             input int exp_done_c, input bit hold, input bit poke);
        int exp_idx = 0;
        int en_cnt  = 0;
        int c       = 1;
        bit fin     = 1'b0;
        bit st;
        key_len = kl;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = hold;
        while (!fin && c < 64) begin
            if (poke) begin
                if (c == 5) begin
                    start   = 1'b1;
                    key_len = 2'b11;
                end else if (c == 6) begin
                    start   = 1'b0;
                    key_len = kl;
                end
            end
            st    = smask[c];
            stall = st;
            @(negedge clk);
            chk("busy_run", 32'(busy), 32'd1);
            chk("round_en", 32'(round_en), 32'(!st));
            chk("round_idx", 32'(round_idx), 32'(exp_idx));
            chk("last_round", 32'(last_round), 32'(!st && exp_idx == n - 1));
            chk("done_early", 32'(done), 32'd0);
            chk("err_run", 32'(err), 32'd0);
            if (kl == 2'b00 && exp_idx == 0) chk("delta_128_i0", delta_rot, 32'hc3efe9db);
            if (kl == 2'b00 && exp_idx == 1) chk("delta_128_i1", delta_rot, 32'h88c4d604);
            if (kl == 2'b00 && exp_idx == 4) chk("delta_128_i4", delta_rot, 32'h3efe9dbc);
            if (kl == 2'b10 && exp_idx == 7) chk("delta_256_i7", delta_rot, 32'he204abf2);
            if (kl == 2'b01 && exp_idx == 6) chk("delta_192_i6", delta_rot, 32'hfbfa76f0);
            if (!st) begin
                en_cnt++;
                if (exp_idx == n - 1) fin = 1'b1;
                else exp_idx++;
            end
            @(posedge clk);
            #1;
            c++;
        end
        stall = 1'b0;
        @(negedge clk);
        chk("run_bounded", 32'(fin), 32'd1);
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd1);
        chk("round_en_done", 32'(round_en), 32'd0);
        chk("idx_held", 32'(round_idx), 32'(n - 1));
        chk("en_count", 32'(en_cnt), 32'(n));
        chk("done_cycle", 32'(c), 32'(exp_done_c));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("done_once", 32'(done), 32'd0);
        chk("idx_idle", 32'(round_idx), 32'd0);
    endtask

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        key_len = 2'b00;
        stall   = 1'b0;
        #22;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_round_en", 32'(round_en), 32'd0);
        chk("rst_idx", 32'(round_idx), 32'd0);
        chk("rst_last", 32'(last_round), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_delta", delta_rot, 32'hc3efe9db);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 128-bit, no stall
        run_check(2'b00, 24, 64'd0, 25, 1'b0, 1'b0);

        // 256-bit, no stall
        run_check(2'b10, 32, 64'd0, 33, 1'b0, 1'b0);

        // 192-bit, stall 3 cycles at idx 5 (cycles 6..8) and 1 cycle at idx 27 (cycle 31)
        run_check(2'b01, 28, (64'd1 << 6) | (64'd1 << 7) | (64'd1 << 8) | (64'd1 << 31),
                  33, 1'b0, 1'b0);

        // Illegal key length
        key_len = 2'b11;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("err_pulse", 32'(err), 32'd1);
        chk("err_busy", 32'(busy), 32'd0);
        chk("err_round_en", 32'(round_en), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("err_one_cycle", 32'(err), 32'd0);
        chk("err_still_idle", 32'(busy), 32'd0);

        // Start and key_len change during RUN are ignored
        run_check(2'b00, 24, 64'd0, 25, 1'b0, 1'b1);

        // Asynchronous reset mid-run at idx 10
        key_len = 2'b00;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        chk("pre_rst_idx", 32'(round_idx), 32'd10);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_round_en", 32'(round_en), 32'd0);
        chk("arst_idx", 32'(round_idx), 32'd0);
        chk("arst_last", 32'(last_round), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_delta", delta_rot, 32'hc3efe9db);
        repeat (3) begin
            @(negedge clk);
            chk("arst_no_done", 32'(done), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_no_done", 32'(done), 32'd0);
        run_check(2'b00, 24, 64'd0, 25, 1'b0, 1'b0);

        // start held high: back-to-back runs
        run_check(2'b00, 24, 64'd0, 25, 1'b1, 1'b0);
        run_check(2'b00, 24, 64'd0, 25, 1'b1, 1'b0);
        start = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("b2b_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
